// File: rtl/persiana_motor_scheduler.sv
// Blind motor sequencer: arbitrates manual vs light-sensor targets, drives the motor with reversal dead time and travel timeout.
// Optional build macro PERSIANA_AUTO_HYST_EN adds an AUTO_HYST-tick stability filter on automatic requests.
module persiana_motor_scheduler #(
  parameter int DEAD_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 200,
  parameter int CW            = 8
`ifdef PERSIANA_AUTO_HYST_EN
  ,
  parameter int AUTO_HYST     = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       man_valid,
  input  logic [1:0] man_cmd,
  input  logic       auto_en,
  input  logic [1:0] sensor,
  input  logic       s_sup,
  input  logic       s_med,
  input  logic       s_inf,
  output logic       motor_up,
  output logic       motor_down,
  output logic       busy,
  output logic       fault,
  output logic [1:0] target,
  output logic       cmd_ack
);

  typedef enum logic [2:0] {IDLE, DEAD, MOVE_UP, MOVE_DOWN, FAULT} state_e;
  typedef enum logic [1:0] {SEEN_UNK, SEEN_SUP, SEEN_MED, SEEN_INF} seen_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  state_e        state_q, state_d;
  seen_e         last_seen_q, last_seen_d, seen_now;
  logic          last_dir_q, last_dir_d;
  logic          moved_q, moved_d;
  logic          pend_dir_q, pend_dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    target_q, target_d;
  logic          motor_up_q, motor_up_d;
  logic          motor_down_q, motor_down_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;
  logic          cmd_ack_q, cmd_ack_d;

  logic [3:0]    at_pos;
  logic          conflict, man_acc, auto_ok, req, req_dir, mid_dir, cur_dir;
  logic [1:0]    req_t;

`ifdef PERSIANA_AUTO_HYST_EN
  logic [1:0]    hyst_val_q, hyst_val_d;
  logic [CW-1:0] hyst_cnt_q, hyst_cnt_d;
`endif

  // Indexed by a target code: 11 open/s_sup, 10 mid/s_med, 01 close/s_inf, 00 never reached.
  assign at_pos = {s_sup, s_med, s_inf, 1'b0};

  always_comb begin
    seen_now = last_seen_q;
    if (s_inf) seen_now = SEEN_INF;
    if (s_med) seen_now = SEEN_MED;
    if (s_sup) seen_now = SEEN_SUP;

    conflict = (s_sup & s_inf) | (s_med & (s_sup | s_inf));
    man_acc  = man_valid && (man_cmd != 2'b00) && (state_q != FAULT);
    mid_dir  = ((seen_now == SEEN_SUP) ||
                ((seen_now == SEEN_MED) && (last_dir_q == DIR_UP))) ? DIR_DOWN : DIR_UP;
    cur_dir  = (state_q == MOVE_UP);

`ifdef PERSIANA_AUTO_HYST_EN
    hyst_val_d = hyst_val_q;
    hyst_cnt_d = hyst_cnt_q;
    if (state_q != IDLE) begin
      hyst_cnt_d = '0;
    end else if (tick) begin
      if (sensor == 2'b00) begin
        hyst_cnt_d = '0;
      end else if (sensor == hyst_val_q) begin
        if (hyst_cnt_q < CW'(AUTO_HYST)) hyst_cnt_d = hyst_cnt_q + CW'(1);
      end else begin
        hyst_val_d = sensor;
        hyst_cnt_d = CW'(1);
      end
    end
    auto_ok = tick && auto_en && (sensor != 2'b00) && !at_pos[sensor] &&
              (hyst_cnt_d >= CW'(AUTO_HYST));
`else
    auto_ok = tick && auto_en && (sensor != 2'b00) && !at_pos[sensor];
`endif

    req   = 1'b0;
    req_t = 2'b00;
    if (man_acc) begin
      req   = 1'b1;
      req_t = man_cmd;
    end else if ((state_q == IDLE) && auto_ok) begin
      req   = 1'b1;
      req_t = sensor;
    end
    case (req_t)
      2'b11:   req_dir = DIR_UP;
      2'b10:   req_dir = mid_dir;
      default: req_dir = DIR_DOWN;
    endcase

    state_d     = state_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    last_seen_d = seen_now;
    last_dir_d  = last_dir_q;
    moved_d     = moved_q;
    pend_dir_d  = pend_dir_q;
    cmd_ack_d   = man_acc && !conflict;

    if (conflict) begin
      state_d  = FAULT;
      target_d = 2'b00;
    end else if (req) begin
      if (at_pos[req_t]) begin
        state_d  = IDLE;
        target_d = 2'b00;
      end else begin
        target_d = req_t;
        case (state_q)
          IDLE: begin
            // First move after reset, or same direction as last time, needs no dead time.
            if (!moved_q || (req_dir == last_dir_q)) begin
              state_d    = req_dir ? MOVE_UP : MOVE_DOWN;
              cnt_d      = '0;
              last_dir_d = req_dir;
              moved_d    = 1'b1;
            end else begin
              state_d    = DEAD;
              cnt_d      = '0;
              pend_dir_d = req_dir;
            end
          end
          DEAD: pend_dir_d = req_dir;
          MOVE_UP, MOVE_DOWN: begin
            if (req_dir != cur_dir) begin
              state_d    = DEAD;
              cnt_d      = '0;
              pend_dir_d = req_dir;
            end
          end
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        DEAD: begin
          if (tick) begin
            if (cnt_q == CW'(DEAD_TICKS - 1)) begin
              state_d    = pend_dir_q ? MOVE_UP : MOVE_DOWN;
              cnt_d      = '0;
              last_dir_d = pend_dir_q;
              moved_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (at_pos[target_q]) begin
            state_d  = IDLE;
            target_d = 2'b00;
          end else if (tick) begin
            if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
              state_d  = FAULT;
              target_d = 2'b00;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    motor_up_d   = (state_d == MOVE_UP);
    motor_down_d = (state_d == MOVE_DOWN);
    busy_d       = (state_d != IDLE);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      target_q     <= 2'b00;
      cnt_q        <= '0;
      last_seen_q  <= SEEN_UNK;
      last_dir_q   <= DIR_UP;
      moved_q      <= 1'b0;
      pend_dir_q   <= DIR_UP;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      cmd_ack_q    <= 1'b0;
`ifdef PERSIANA_AUTO_HYST_EN
      hyst_val_q   <= 2'b00;
      hyst_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      last_seen_q  <= last_seen_d;
      last_dir_q   <= last_dir_d;
      moved_q      <= moved_d;
      pend_dir_q   <= pend_dir_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      cmd_ack_q    <= cmd_ack_d;
`ifdef PERSIANA_AUTO_HYST_EN
      hyst_val_q   <= hyst_val_d;
      hyst_cnt_q   <= hyst_cnt_d;
`endif
    end
  end

  assign motor_up   = motor_up_q;
  assign motor_down = motor_down_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign target     = target_q;
  assign cmd_ack    = cmd_ack_q;

endmodule

// File: tb/tb_persiana_motor_scheduler.sv
// Bench for persiana_motor_scheduler: directed scenarios checked against a behavioural blind model every cycle.
module tb_persiana_motor_scheduler;

  localparam int DEAD_TICKS    = 4;
  localparam int TIMEOUT_TICKS = 200;
  localparam int AUTO_HYST     = 3;
`ifdef PERSIANA_AUTO_HYST_EN
  localparam int AUTO_WAIT = 6;
`else
  localparam int AUTO_WAIT = 2;
`endif

  localparam int MD_IDLE = 0, MD_DEAD = 1, MD_UP = 2, MD_DOWN = 3, MD_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       man_valid = 1'b0;
  logic [1:0] man_cmd = 2'b00;
  logic       auto_en = 1'b0;
  logic [1:0] sensor = 2'b00;
  logic       s_sup = 1'b0, s_med = 1'b0, s_inf = 1'b0;
  logic       motor_up, motor_down, busy, fault, cmd_ack;
  logic [1:0] target;

  int tests = 0;
  int failures = 0;

  // Model of the blind: mode, remaining dead ticks, ticks travelled, where it was last seen.
  int         m_mode, m_dead_left, m_run, m_seen, m_last_dir, m_pend, m_hcnt;
  bit         m_moved, m_ack;
  logic [1:0] m_target, m_hval;

  persiana_motor_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .man_valid(man_valid), .man_cmd(man_cmd),
    .auto_en(auto_en), .sensor(sensor), .s_sup(s_sup), .s_med(s_med), .s_inf(s_inf),
    .motor_up(motor_up), .motor_down(motor_down), .busy(busy), .fault(fault),
    .target(target), .cmd_ack(cmd_ack)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = ~tick;
  end

  function automatic bit atPos(input logic [1:0] t);
    case (t)
      2'b11:   return s_sup;
      2'b10:   return s_med;
      2'b01:   return s_inf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] expVec();
    return {m_mode == MD_UP, m_mode == MD_DOWN, m_mode != MD_IDLE, m_mode == MD_FAULT,
            m_target, m_ack};
  endfunction

  function automatic logic [6:0] dutVec();
    return {motor_up, motor_down, busy, fault, target, cmd_ack};
  endfunction

  task automatic modelReset();
    m_mode = MD_IDLE; m_dead_left = 0; m_run = 0; m_seen = 0; m_last_dir = 1;
    m_pend = 1; m_hcnt = 0; m_moved = 0; m_ack = 0; m_target = 2'b00; m_hval = 2'b00;
  endtask

  task automatic startMove(input int d);
    m_mode = (d > 0) ? MD_UP : MD_DOWN;
    m_run = 0; m_last_dir = d; m_moved = 1;
  endtask

  task automatic enterDead(input int d);
    m_mode = MD_DEAD; m_dead_left = DEAD_TICKS; m_pend = d;
  endtask

  task automatic handleRequest(input logic [1:0] t, input int seen);
    int d;
    if (atPos(t)) begin
      m_mode = MD_IDLE; m_target = 2'b00;
      return;
    end
    if (t == 2'b11) d = 1;
    else if (t == 2'b01) d = -1;
    else d = (seen == 1 || (seen == 2 && m_last_dir == 1)) ? -1 : 1;
    m_target = t;
    if (m_mode == MD_IDLE) begin
      if (!m_moved || d == m_last_dir) startMove(d); else enterDead(d);
    end else if (m_mode == MD_DEAD) begin
      m_pend = d;
    end else if (d != ((m_mode == MD_UP) ? 1 : -1)) begin
      enterDead(d);
    end
  endtask

  task automatic modelStep();
    int seen;
    bit conflict, accept, fire;
    seen = s_sup ? 1 : s_med ? 2 : s_inf ? 3 : m_seen;
    conflict = (s_sup && s_inf) || (s_med && (s_sup || s_inf));
    accept = man_valid && man_cmd != 2'b00 && m_mode != MD_FAULT;
    fire = m_mode == MD_IDLE && tick && auto_en && sensor != 2'b00 && !atPos(sensor);
`ifdef PERSIANA_AUTO_HYST_EN
    if (m_mode != MD_IDLE) m_hcnt = 0;
    else if (tick) begin
      if (sensor == 2'b00) m_hcnt = 0;
      else if (sensor == m_hval) m_hcnt++;
      else begin m_hval = sensor; m_hcnt = 1; end
    end
    fire = fire && (m_hcnt >= AUTO_HYST);
`endif
    m_ack = accept && !conflict;
    if (conflict) begin
      m_mode = MD_FAULT; m_target = 2'b00;
    end else if (accept) begin
      handleRequest(man_cmd, seen);
    end else if (fire) begin
      handleRequest(sensor, seen);
    end else if (m_mode == MD_DEAD) begin
      if (tick) begin
        m_dead_left--;
        if (m_dead_left == 0) startMove(m_pend);
      end
    end else if (m_mode == MD_UP || m_mode == MD_DOWN) begin
      if (atPos(m_target)) begin
        m_mode = MD_IDLE; m_target = 2'b00;
      end else if (tick) begin
        m_run++;
        if (m_run == TIMEOUT_TICKS) begin m_mode = MD_FAULT; m_target = 2'b00; end
      end
    end
    m_seen = seen;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) modelReset(); else modelStep();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    tests++;
    if (dutVec() !== expVec()) begin
      failures++;
      $display("[TB] FAIL cycle_model t=%0t got=%b want=%b (up,down,busy,fault,target,ack)",
               $time, dutVec(), expVec());
    end
  end

  task automatic checkOutput(input string name, input logic [6:0] want);
    tests++;
    if (dutVec() !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%b want=%b (up,down,busy,fault,target,ack)", name, dutVec(), want);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic ae,
                               input logic [1:0] sens);
    @(negedge clk);
    man_valid = v; man_cmd = c; auto_en = ae; sensor = sens;
    @(negedge clk);
    man_valid = 1'b0; man_cmd = 2'b00;
  endtask

  task automatic sensors(input logic sup, input logic med, input logic inf);
    @(negedge clk);
    s_sup = sup; s_med = med; s_inf = inf;
    @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; man_valid = 1'b0; man_cmd = 2'b00; auto_en = 1'b0; sensor = 2'b00;
    s_sup = 1'b0; s_med = 1'b0; s_inf = 1'b0;
    waitCycles(2);
    reset = 1'b0;
  endtask

  initial begin
    waitCycles(3);
    reset = 1'b0;
    checkOutput("reset_state", 7'b0000000);

    // Bottom to top with the first move after reset.
    sensors(0, 0, 1);
    applyStimulus(1, 2'b11, 0, 2'b00);
    checkOutput("t1_ack_up", 7'b1010111);
    sensors(0, 0, 0);
    checkOutput("t1_moving", 7'b1010110);
    sensors(1, 0, 0);
    checkOutput("t1_stop_top", 7'b0000000);

    // Reversal mid-travel goes through the dead time.
    sensors(0, 0, 0);
    applyStimulus(1, 2'b11, 0, 2'b00);
    checkOutput("t2_up_again", 7'b1010111);
    waitCycles(2);
    applyStimulus(1, 2'b01, 0, 2'b00);
    checkOutput("t2_dead", 7'b0010011);
    waitCycles(2);
    checkOutput("t2_still_dead", 7'b0010010);
    waitCycles(10);
    checkOutput("t2_down", 7'b0110010);
    sensors(0, 0, 1);
    checkOutput("t2_stop_bottom", 7'b0000000);

    // Mid from above travels down.
    sensors(1, 0, 0);
    sensors(0, 0, 0);
    applyStimulus(1, 2'b10, 0, 2'b00);
    checkOutput("t3_mid_down", 7'b0110101);
    waitCycles(2);
    sensors(0, 1, 0);
    checkOutput("t3_stop_mid", 7'b0000000);
    sensors(0, 0, 1);
    applyStimulus(1, 2'b01, 0, 2'b00);
    checkOutput("acc_reached", 7'b0000001);

    // Manual beats a simultaneous automatic request.
    applyStimulus(1, 2'b11, 1, 2'b01);
    checkOutput("t5_manual_wins", 7'b0010111);
    auto_en = 1'b0; sensor = 2'b00;
    waitCycles(12);
    checkOutput("t5_up", 7'b1010110);
    sensors(1, 0, 0);
    checkOutput("t5_stop_top", 7'b0000000);

    // Automatic close request from the top.
    sensors(0, 0, 0);
    applyStimulus(0, 2'b00, 1, 2'b01);
    waitCycles(AUTO_WAIT);
    checkOutput("auto_dead", 7'b0010010);
    waitCycles(12);
    checkOutput("auto_down", 7'b0110010);
    sensors(0, 0, 1);
    checkOutput("auto_stop", 7'b0000000);
    waitCycles(8);
    checkOutput("auto_reached_idle", 7'b0000000);
    applyStimulus(0, 2'b00, 0, 2'b00);

    // Travel timeout.
    sensors(0, 0, 0);
    applyStimulus(1, 2'b01, 0, 2'b00);
    checkOutput("t4_start_down", 7'b0110011);
    waitCycles(380);
    checkOutput("t4_running", 7'b0110010);
    waitCycles(30);
    checkOutput("t4_fault", 7'b0011000);
    applyStimulus(1, 2'b11, 0, 2'b00);
    checkOutput("t4_no_ack", 7'b0011000);

    // Reset mid-motion drops the motor without a clock edge.
    doReset();
    applyStimulus(1, 2'b11, 0, 2'b00);
    checkOutput("rst_move_up", 7'b1010111);
    waitCycles(1);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 7'b0000000);
    waitCycles(2);
    reset = 1'b0;

    // Sensor conflict.
    sensors(1, 0, 1);
    checkOutput("t6_conflict", 7'b0011000);
    doReset();
    sensors(0, 1, 1);
    checkOutput("t6_conflict_med", 7'b0011000);
    doReset();

`ifdef PERSIANA_AUTO_HYST_EN
    auto_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sensor = (i % 2 == 1) ? 2'b10 : 2'b11;
      waitCycles(2);
    end
    checkOutput("t6_hyst_no_motion", 7'b0000000);
    auto_en = 1'b0; sensor = 2'b00;
`endif
    waitCycles(2);

    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
